// File: rtl/cpu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_fetch_unit
// Purpose  : Instruction fetch responder for the CPU controller. It holds the
//            program counter, program memory, a one-entry prefetch buffer and
//            the instruction register. A loadIR strobe is served in the same
//            cycle when the prefetch buffer is valid. Otherwise the block
//            stalls and captures the instruction once the buffer fills.
// Ports    : clk, rst_n (async, active low), en (synchronous run enable)
//            loadIR / loadPC / jump_en / jump_addr : controller strobes
//            prog_we / prog_addr / prog_data       : program memory writes
//            pc, opcode, operand, ir_valid, fetch_stall, parity_err : status
// Options  : FETCH_PARITY_EN adds an even-parity bit to every memory word and
//            a sticky parity_err flag. When it is undefined, parity_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_fetch_unit #(
    parameter int OPCODE  = 4,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      loadIR,
    input  logic                      loadPC,
    input  logic                      jump_en,
    input  logic [ADDR_W-1:0]         jump_addr,
    input  logic                      prog_we,
    input  logic [ADDR_W-1:0]         prog_addr,
    input  logic [INSTR_W-1:0]        prog_data,
    output logic [ADDR_W-1:0]         pc,
    output logic [OPCODE-1:0]         opcode,
    output logic [INSTR_W-OPCODE-1:0] operand,
    output logic                      ir_valid,
    output logic                      fetch_stall,
    output logic                      parity_err
);

`ifdef FETCH_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_READY = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t               r_state, w_state_d;
    logic [ADDR_W-1:0]    r_pc, w_pc_d;
    logic [MEM_W-1:0]     r_mem [DEPTH];
    logic [MEM_W-1:0]     r_pf_data;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_ir_valid;
    logic                 r_pend_pc, r_pend_jump;
    logic [ADDR_W-1:0]    r_pend_addr;
    logic                 w_hit, w_capture, w_pend_load, w_pf_load;
    logic [MEM_W-1:0]     w_wr_word, w_rd_word;
    logic [ADDR_W-1:0]    w_pc_step;

`ifdef FETCH_PARITY_EN
    assign w_wr_word = {^prog_data, prog_data};
`else
    assign w_wr_word = prog_data;
`endif

    // Write-first: a read of the address being written sees the new word.
    assign w_hit     = prog_we && (prog_addr == r_pc);
    assign w_rd_word = w_hit ? w_wr_word : r_mem[r_pc];
    assign w_pc_step = jump_en ? jump_addr : (r_pc + c_pc_one);

    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= w_wr_word;
        end
    end

    // State and PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_d   = r_state;
        w_pc_d      = r_pc;
        w_capture   = 1'b0;
        w_pend_load = 1'b0;
        w_pf_load   = 1'b0;
        case (r_state)
            S_FILL: begin
                w_pf_load = 1'b1;
                if (loadIR) begin
                    w_pend_load = 1'b1;
                    w_state_d   = S_STALL;
                end else if (loadPC) begin
                    // The read issued this cycle belongs to the old PC.
                    w_pc_d    = w_pc_step;
                    w_state_d = S_FILL;
                end else begin
                    w_state_d = S_READY;
                end
            end
            S_READY: begin
                if (w_hit) begin
                    // The buffered word is being overwritten, so refetch it.
                    // A loadIR in this cycle waits for the new word.
                    if (loadIR) begin
                        w_pf_load   = 1'b1;
                        w_pend_load = 1'b1;
                        w_state_d   = S_STALL;
                    end else begin
                        if (loadPC) begin
                            w_pc_d = w_pc_step;
                        end
                        w_state_d = S_FILL;
                    end
                end else begin
                    w_capture = loadIR;
                    if (loadPC) begin
                        w_pc_d    = w_pc_step;
                        w_state_d = S_FILL;
                    end
                end
            end
            S_STALL: begin
                if (w_hit) begin
                    // Pick up the new word, then capture it one cycle later.
                    w_pf_load = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    if (r_pend_pc) begin
                        w_pc_d = r_pend_jump ? r_pend_addr : (r_pc + c_pc_one);
                    end
                    w_state_d = (w_pc_d != r_pc) ? S_FILL : S_READY;
                end
            end
            default: w_state_d = S_FILL;
        endcase
        if (!en) begin
            w_state_d   = S_FILL;
            w_pc_d      = '0;
            w_capture   = 1'b0;
            w_pend_load = 1'b0;
            w_pf_load   = 1'b0;
        end
    end

    // Datapath: prefetch buffer, pending PC update and IR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pf_data   <= '0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_pend_pc   <= 1'b0;
            r_pend_jump <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            r_ir_valid <= w_capture;
            if (w_pf_load) begin
                r_pf_data <= w_rd_word;
            end
            if (!en) begin
                r_ir        <= '0;
                r_pend_pc   <= 1'b0;
                r_pend_jump <= 1'b0;
                r_pend_addr <= '0;
            end else begin
                if (w_capture) begin
                    r_ir <= r_pf_data[INSTR_W-1:0];
                end
                if (w_pend_load) begin
                    r_pend_pc   <= loadPC;
                    r_pend_jump <= jump_en;
                    r_pend_addr <= jump_addr;
                end
            end
        end
    end

`ifdef FETCH_PARITY_EN
    logic r_parity_err;

    // The XOR of data and the stored parity bit is zero for a good word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_capture && (^r_pf_data)) begin
            r_parity_err <= 1'b1;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign pc          = r_pc;
    assign opcode      = r_ir[INSTR_W-1 -: OPCODE];
    assign operand     = r_ir[INSTR_W-OPCODE-1:0];
    assign ir_valid    = r_ir_valid;
    assign fetch_stall = (r_state == S_STALL);

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_fetch_unit
// Purpose  : Directed self-checking bench for cpu_fetch_unit. It covers reset,
//            buffered and stalled fetches, PC wrap, jumps, program-write
//            invalidation, the en clear and (with FETCH_PARITY_EN) parity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, en, loadIR, loadPC, jump_en, prog_we;
    logic [7:0]  jump_addr, prog_addr, pc;
    logic [15:0] prog_data;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        ir_valid, fetch_stall, parity_err;

    int n_pass  = 0;
    int n_total = 0;

    cpu_fetch_unit #(.OPCODE(4), .ADDR_W(8), .INSTR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .loadIR(loadIR), .loadPC(loadPC),
        .jump_en(jump_en), .jump_addr(jump_addr), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .pc(pc),
        .opcode(opcode), .operand(operand), .ir_valid(ir_valid),
        .fetch_stall(fetch_stall), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic prog(input logic [7:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic strobes(input logic ir, input logic pcs, input logic j, input logic [7:0] ja);
        loadIR = ir; loadPC = pcs; jump_en = j; jump_addr = ja;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        strobes(0, 0, 0, 8'h00);
        tick(); tick();
        check("rst_pc", pc, 0);
        check("rst_opcode", opcode, 0);
        check("rst_operand", operand, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_stall", fetch_stall, 0);
        check("rst_parity", parity_err, 0);
        rst_n = 1'b1;

        // Load the program while the unit is held idle.
        prog(8'h00, 16'h3A55);
        prog(8'h40, 16'h2123);
        prog(8'hFF, 16'hD00F);
        prog(8'h05, 16'h1234);
        prog(8'h02, 16'h0003);

        // Buffered LOAD cycle: one-cycle latency, no stall.
        en = 1'b1;
        tick(); tick();
        strobes(1, 1, 0, 8'h00);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t1_opcode", opcode, 4'h3);
        check("t1_operand", operand, 12'hA55);
        check("t1_ir_valid", ir_valid, 1);
        check("t1_pc", pc, 1);
        check("t1_stall", fetch_stall, 0);
        tick();
        check("t1_ir_valid_pulse", ir_valid, 0);

        // LOAD cycle while FILL: one stall cycle, then capture.
        en = 1'b0;
        prog(8'h00, 16'h1001);
        check("t2_clear_pc", pc, 0);
        check("t2_clear_opcode", opcode, 0);
        en = 1'b1;
        strobes(1, 1, 0, 8'h00);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t2_stall", fetch_stall, 1);
        check("t2_ir_valid_wait", ir_valid, 0);
        check("t2_pc_hold", pc, 0);
        tick();
        check("t2_stall_clear", fetch_stall, 0);
        check("t2_opcode", opcode, 4'h1);
        check("t2_operand", operand, 12'h001);
        check("t2_pc", pc, 1);
        check("t2_ir_valid", ir_valid, 1);

        // PC wrap from 0xFF.
        strobes(0, 1, 1, 8'hFF);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t3_jump_pc", pc, 8'hFF);
        tick();
        strobes(1, 1, 0, 8'h00);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t3_opcode", opcode, 4'hD);
        check("t3_operand", operand, 12'h00F);
        check("t3_pc_wrap", pc, 8'h00);

        // Jump, then a later loadIR.
        tick();
        strobes(0, 1, 1, 8'h40);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t4_pc", pc, 8'h40);
        tick(); tick();
        strobes(1, 0, 0, 8'h00);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t4_opcode", opcode, 4'h2);
        check("t4_operand", operand, 12'h123);
        check("t4_pc_hold", pc, 8'h40);

        // A write to the word under the PC invalidates the buffer.
        strobes(0, 1, 1, 8'h05);
        tick();
        strobes(0, 0, 0, 8'h00);
        tick();
        prog(8'h05, 16'hF0F0);
        tick();
        strobes(1, 0, 0, 8'h00);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t5_opcode", opcode, 4'hF);
        check("t5_operand", operand, 12'h0F0);
        en = 1'b0;
        tick();
        check("t5_en_pc", pc, 0);
        check("t5_en_opcode", opcode, 0);
        check("t5_en_operand", operand, 0);
        check("t5_en_ir_valid", ir_valid, 0);

        // A write to the PC word while stalled is captured one cycle later.
        en = 1'b1;
        strobes(1, 0, 0, 8'h00);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t6_stall", fetch_stall, 1);
        prog(8'h00, 16'h7777);
        check("t6_stall_extra", fetch_stall, 1);
        check("t6_no_capture", ir_valid, 0);
        tick();
        check("t6_opcode", opcode, 4'h7);
        check("t6_operand", operand, 12'h777);
        check("t6_stall_clear", fetch_stall, 0);
        check("t6_pc", pc, 0);

`ifdef FETCH_PARITY_EN
        // Corrupt the stored parity bit of mem[2] and fetch it.
        dut.r_mem[2] = dut.r_mem[2] ^ 17'h10000;
        strobes(0, 1, 1, 8'h02);
        tick();
        strobes(0, 0, 0, 8'h00);
        tick();
        check("t7_parity_before", parity_err, 0);
        strobes(1, 0, 0, 8'h00);
        tick();
        strobes(0, 0, 0, 8'h00);
        check("t7_opcode", opcode, 4'h0);
        check("t7_parity_set", parity_err, 1);
        en = 1'b0;
        tick();
        check("t7_parity_sticky", parity_err, 1);
        rst_n = 1'b0;
        #1;
        check("t7_parity_reset", parity_err, 0);
        rst_n = 1'b1;
`else
        check("t7_parity_tied", parity_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
